// File: rtl/matrix_job_sequencer.sv
// Job sequencer for a matrix accelerator: streams X words per matrix, waits for
// finish with a timeout, inserts an inter-matrix gap, then reads back 18-bit results.
module matrix_job_sequencer #(
    parameter int MATRIX_NUM = 2,
    parameter int LOAD_WORDS = 32,
    parameter int RES_WORDS  = 16,
    parameter int GAP_CYCLES = 100,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_go,
    output logic [7:0]  in_addr,
    input  logic [7:0]  in_data,
    output logic        start_in,
    output logic        valid_input,
    output logic [7:0]  X_load,
    input  logic        finish,
    output logic        read_n,
    output logic [7:0]  r_addr,
    input  logic [8:0]  read_data,
    output logic        res_valid,
    output logic [17:0] res_data,
    output logic [7:0]  res_idx,
    output logic        busy,
    output logic        done,
    output logic        err_timeout
);

    // MATRIX_NUM*LOAD_WORDS > 256 is unsupported: in_addr only carries 8 bits.
    localparam int TOTAL_WORDS = MATRIX_NUM * LOAD_WORDS;
    localparam int TOTAL_RES   = MATRIX_NUM * RES_WORDS;
    localparam int CNT_MAX     = (TOTAL_WORDS > TOTAL_RES) ? TOTAL_WORDS : TOTAL_RES;
    localparam int CW          = $clog2(CNT_MAX + 1);
    localparam int TW          = $clog2(TIMEOUT + 1);
    localparam int GW          = $clog2(GAP_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, START, LOAD, WAIT_FIN, GAP,
        RD_STB, RD_W1, RD_W2, RD_LO, RD_HI, DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] m;
    logic [CW-1:0] w;
    logic [CW-1:0] r;
    logic [CW-1:0] addr;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;

    // Load addresses are consecutive across matrices, so a running counter
    // equals m*LOAD_WORDS+w without a multiplier.
    assign in_addr = 8'(addr);
    assign X_load  = valid_input ? in_data : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            m           <= '0;
            w           <= '0;
            r           <= '0;
            addr        <= '0;
            tcnt        <= '0;
            gcnt        <= '0;
            start_in    <= 1'b0;
            valid_input <= 1'b0;
            read_n      <= 1'b1;
            r_addr      <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            start_in  <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_go) begin
                        m           <= '0;
                        w           <= '0;
                        r           <= '0;
                        addr        <= '0;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        start_in    <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    valid_input <= 1'b1;
                    state       <= LOAD;
                end
                LOAD: begin
                    addr <= addr + 1'b1;
                    if (w == CW'(LOAD_WORDS - 1)) begin
                        w           <= '0;
                        valid_input <= 1'b0;
                        tcnt        <= '0;
                        state       <= WAIT_FIN;
                    end else begin
                        w <= w + 1'b1;
                    end
                end
                WAIT_FIN: begin
                    if (finish) begin
                        m <= m + 1'b1;
                        if (m + 1'b1 < CW'(MATRIX_NUM)) begin
                            gcnt  <= '0;
                            state <= GAP;
                        end else begin
                            read_n <= 1'b0;
                            r_addr <= 8'(r);
                            state  <= RD_STB;
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gcnt == GW'(GAP_CYCLES - 1)) begin
                        start_in <= 1'b1;
                        state    <= START;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                RD_STB: begin
                    read_n <= 1'b1;
                    state  <= RD_W1;
                end
                RD_W1: state <= RD_W2;
                RD_W2: state <= RD_LO;
                RD_LO: begin
                    res_data[8:0] <= read_data;
                    state         <= RD_HI;
                end
                RD_HI: begin
                    res_data[17:9] <= read_data;
                    res_idx        <= 8'(r);
                    res_valid      <= 1'b1;
                    r              <= r + 1'b1;
                    if (r + 1'b1 < CW'(TOTAL_RES)) begin
                        read_n <= 1'b0;
                        r_addr <= 8'(r + 1'b1);
                        state  <= RD_STB;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_job_sequencer.sv
// Directed self-checking bench for matrix_job_sequencer with a simple X memory
// and accelerator readback model.
module tb_matrix_job_sequencer;

    localparam int MATRIX_NUM = 2;
    localparam int LOAD_WORDS = 32;
    localparam int RES_WORDS  = 16;
    localparam int GAP_CYCLES = 100;
    localparam int TIMEOUT    = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_go = 1'b0;
    logic        finish = 1'b0;
    logic [7:0]  in_addr;
    logic [7:0]  in_data;
    logic        start_in;
    logic        valid_input;
    logic [7:0]  X_load;
    logic        read_n;
    logic [7:0]  r_addr;
    logic [8:0]  read_data;
    logic        res_valid;
    logic [17:0] res_data;
    logic [7:0]  res_idx;
    logic        busy;
    logic        done;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    int rphase = 0;

    always #5 clk = ~clk;

    matrix_job_sequencer #(
        .MATRIX_NUM(MATRIX_NUM),
        .LOAD_WORDS(LOAD_WORDS),
        .RES_WORDS (RES_WORDS),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .job_go     (job_go),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .start_in   (start_in),
        .valid_input(valid_input),
        .X_load     (X_load),
        .finish     (finish),
        .read_n     (read_n),
        .r_addr     (r_addr),
        .read_data  (read_data),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout)
    );

    function automatic logic [7:0] mem_word(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    assign in_data = mem_word(in_addr);

    // Accelerator: phase 3 after the strobe is the low half, phase 4 the high half.
    always @(posedge clk) begin
        if (!read_n)                      rphase <= 1;
        else if (rphase != 0 && rphase < 4) rphase <= rphase + 1;
        else                              rphase <= 0;
    end
    assign read_data = (rphase == 3) ? {1'b0, r_addr} :
                       (rphase == 4) ? ~{1'b0, r_addr} : 9'h000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_reset_values(input string tag);
        logic [56:0] got, exp;
        got = {start_in, valid_input, X_load, read_n, r_addr, in_addr, res_valid,
               res_data, res_idx, busy, done, err_timeout};
        exp = {1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 18'h0, 8'h00, 1'b0, 1'b0, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_go_and_check_start(input string tag);
        tick();
        job_go = 1'b1;
        tick();
        job_go = 1'b0;
        checks++;
        if (start_in !== 1'b1 || busy !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s: start_in=%b busy=%b err_timeout=%b expected 1 1 0",
                     tag, start_in, busy, err_timeout);
        end
    endtask

    // Entered in the START cycle; leaves in the first WAIT_FIN cycle.
    task automatic load_matrix(input int m, input int finish_at, input int go_at);
        logic [7:0] exp_addr;
        for (int w = 0; w < LOAD_WORDS; w++) begin
            tick();
            exp_addr = 8'(m * LOAD_WORDS + w);
            checks++;
            if (valid_input !== 1'b1 || in_addr !== exp_addr ||
                X_load !== mem_word(exp_addr) || start_in !== 1'b0) begin
                errors++;
                $display("FAIL load m%0d w%0d: valid=%b addr=%h x=%h start=%b expected 1 %h %h 0",
                         m, w, valid_input, in_addr, X_load, start_in, exp_addr, mem_word(exp_addr));
            end
            finish = (w == finish_at);
            job_go = (w == go_at);
        end
        tick();
        finish = 1'b0;
        job_go = 1'b0;
        checks++;
        if (valid_input !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_end m%0d: valid=%b busy=%b expected 0 1", m, valid_input, busy);
        end
    endtask

    // Entered in the first WAIT_FIN cycle; finish is high in the n-th WAIT_FIN cycle.
    task automatic finish_after(input int n);
        for (int i = 1; i < n; i++) begin
            checks++;
            if (start_in !== 1'b0 || read_n !== 1'b1 || busy !== 1'b1 || valid_input !== 1'b0) begin
                errors++;
                $display("FAIL wait_fin cycle %0d: start=%b read_n=%b busy=%b valid=%b expected 0 1 1 0",
                         i, start_in, read_n, busy, valid_input);
            end
            tick();
        end
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic gap_check(input int pulse_at);
        int n = 0;
        while (start_in !== 1'b1 && n < GAP_CYCLES + 20) begin
            finish = (n == pulse_at);
            tick();
            n++;
        end
        finish = 1'b0;
        checks++;
        if (n !== GAP_CYCLES || start_in !== 1'b1) begin
            errors++;
            $display("FAIL gap_len: got %0d idle cycles (start_in=%b) expected %0d then start_in=1",
                     n, start_in, GAP_CYCLES);
        end
    endtask

    // Entered in the first RD_STB cycle; leaves in the IDLE cycle after done.
    task automatic readback();
        logic [8:0]  iv;
        logic [17:0] exp;
        for (int i = 0; i < MATRIX_NUM * RES_WORDS; i++) begin
            checks++;
            if (read_n !== 1'b0 || r_addr !== 8'(i)) begin
                errors++;
                $display("FAIL rd_stb %0d: read_n=%b r_addr=%h expected 0 %h", i, read_n, r_addr, 8'(i));
            end
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++;
                if (read_n !== 1'b1 || res_valid !== 1'b0 || r_addr !== 8'(i)) begin
                    errors++;
                    $display("FAIL rd_wait %0d.%0d: read_n=%b res_valid=%b r_addr=%h expected 1 0 %h",
                             i, k, read_n, res_valid, r_addr, 8'(i));
                end
            end
            tick();
            iv  = 9'(i);
            exp = {~iv, iv};
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp || res_idx !== 8'(i)) begin
                errors++;
                $display("FAIL result %0d: valid=%b data=%h idx=%h expected 1 %h %h",
                         i, res_valid, res_data, res_idx, exp, 8'(i));
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b err=%b expected 1 1 0", done, busy, err_timeout);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done: done=%b busy=%b res_valid=%b expected 0 0 0",
                     done, busy, res_valid);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1 expect_reset_values("reset_async");
        repeat (3) tick();
        expect_reset_values("reset_held");
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || start_in !== 1'b0 || read_n !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b start=%b read_n=%b expected 0 0 1",
                     busy, start_in, read_n);
        end
    endtask

    task automatic test_full_job();
        pulse_go_and_check_start("full_start");
        load_matrix(0, -1, -1);
        finish_after(50);
        gap_check(-1);
        load_matrix(1, -1, -1);
        finish_after(50);
        readback();
    endtask

    task automatic test_finish_ignored();
        int seen = 0;
        pulse_go_and_check_start("ign_start");
        load_matrix(0, 10, -1);
        job_go = 1'b1;
        tick();
        job_go = 1'b0;
        finish_after(20);
        gap_check(30);
        load_matrix(1, 3, -1);
        finish_after(7);
        readback();
        for (int i = 0; i < 10; i++) begin
            if (busy !== 1'b0 || start_in !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL go_not_queued: %0d busy/start cycles after done expected 0", seen);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int saw_read = 0;
        pulse_go_and_check_start("to_start");
        load_matrix(0, -1, -1);
        while (err_timeout !== 1'b1 && n < TIMEOUT + 50) begin
            if (read_n !== 1'b1) saw_read++;
            tick();
            n++;
        end
        checks++;
        if (n !== TIMEOUT || done !== 1'b1 || saw_read !== 0) begin
            errors++;
            $display("FAIL timeout: err after %0d cycles done=%b reads=%0d expected %0d 1 0",
                     n, done, saw_read, TIMEOUT);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b1 || read_n !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: done=%b busy=%b err=%b read_n=%b expected 0 0 1 1",
                     done, busy, err_timeout, read_n);
        end
        repeat (5) tick();
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err_timeout=%b expected 1", err_timeout);
        end
    endtask

    task automatic test_abort();
        int bad = 0;
        pulse_go_and_check_start("abort_start");
        load_matrix(0, -1, 5);
        finish_after(10);
        gap_check(-1);
        repeat (18) tick();
        checks++;
        if (in_addr !== 8'd49 || valid_input !== 1'b1) begin
            errors++;
            $display("FAIL abort_word17: in_addr=%h valid=%b expected 31 1", in_addr, valid_input);
        end
        rst = 1'b0;
        #1 expect_reset_values("abort_reset");
        repeat (3) tick();
        expect_reset_values("abort_reset_held");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid !== 1'b0 || busy !== 1'b0 || start_in !== 1'b0 || valid_input !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d active cycles after reset release expected 0", bad);
        end
        pulse_go_and_check_start("restart");
        load_matrix(0, -1, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_job();
        test_finish_ignored();
        test_timeout();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_job_sequencer.md
MATRIX_JOB_SEQUENCER -- requirements
Module: matrix_job_sequencer

Parameters
REQ-001 SHALL have parameter MATRIX_NUM, default 2: matrices per job.
REQ-002 SHALL have parameter LOAD_WORDS, default 32: 8-bit X words per matrix.
REQ-003 SHALL have parameter RES_WORDS, default 16: 18-bit results per matrix.
REQ-004 SHALL have parameter GAP_CYCLES, default 100: idle cycles between finish and the next matrix start_in.
REQ-005 SHALL have parameter TIMEOUT, default 4096: maximum cycles to wait for finish.

Interface
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port job_go, input, 1: one-cycle request to run a job; sampled only in IDLE.
REQ-009 SHALL have port in_addr, output, 8: X memory word address.
REQ-010 SHALL have port in_data, input, 8: X word, combinational from in_addr.
REQ-011 SHALL have port start_in, output, 1: accelerator matrix start pulse.
REQ-012 SHALL have port valid_input, output, 1: X_load valid qualifier.
REQ-013 SHALL have port X_load, output, 8: X word to the accelerator.
REQ-014 SHALL have port finish, input, 1: accelerator matrix-complete level.
REQ-015 SHALL have port read_n, output, 1: active-low result read strobe.
REQ-016 SHALL have port r_addr, output, 8: result address.
REQ-017 SHALL have port read_data, input, 9: result half-word from the accelerator.
REQ-018 SHALL have ports res_valid, output, 1; res_data, output, 18; res_idx, output, 8: assembled result stream.
REQ-019 SHALL have ports busy, output, 1; done, output, 1; err_timeout, output, 1: job status.

Function
REQ-020 SHALL implement the states IDLE, START, LOAD, WAIT_FIN, GAP, RD_STB, RD_W1, RD_W2, RD_LO, RD_HI, and DONE.
REQ-021 In IDLE with job_go=1, the FSM SHALL clear the matrix counter m, the word counter w, and the result counter r, and go to START.
REQ-022 START SHALL drive start_in=1 for exactly one cycle, then go to LOAD.
REQ-023 LOAD SHALL last exactly LOAD_WORDS cycles with valid_input=1, in_addr=m*LOAD_WORDS+w, X_load=in_data (combinational, same cycle), and w incrementing each cycle.
REQ-024 After w=LOAD_WORDS-1, the FSM SHALL go to WAIT_FIN and clear w.
REQ-025 WAIT_FIN SHALL count cycles; on finish=1 it SHALL increment m.
REQ-026 On finish=1 in WAIT_FIN, the FSM SHALL go to GAP if m<MATRIX_NUM, else to RD_STB.
REQ-027 If finish does not arrive within TIMEOUT cycles, the FSM SHALL set err_timeout=1 (sticky until the next job_go) and go to DONE.
REQ-028 GAP SHALL wait exactly GAP_CYCLES cycles, then go to START.
REQ-029 finish SHALL be ignored in every state except WAIT_FIN.
REQ-030 RD_STB SHALL drive read_n=0 and r_addr=r for one cycle.
REQ-031 RD_W1 and RD_W2 SHALL keep read_n=1 and hold r_addr.
REQ-032 RD_LO SHALL capture read_data into bits [8:0]; RD_HI SHALL capture read_data into bits [17:9].
REQ-033 In the cycle after RD_HI, the block SHALL assert res_valid=1 for one cycle with res_data set to the full word and res_idx=r.
REQ-034 After RD_HI, the block SHALL increment r and return to RD_STB if r<MATRIX_NUM*RES_WORDS, else go to DONE.
REQ-035 A result read SHALL take 5 cycles, so a full readback of 32 results SHALL take 160 cycles.
REQ-036 DONE SHALL pulse done=1 for one cycle, then go to IDLE.
REQ-037 busy SHALL be 1 in every state except IDLE.
REQ-038 job_go asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-039 Counters SHALL be sized to hold MATRIX_NUM*LOAD_WORDS without wrap.
REQ-040 in_addr SHALL be truncated to 8 bits.
REQ-041 Configurations with MATRIX_NUM*LOAD_WORDS>256 SHALL be unsupported.

Reset
REQ-042 While rst=0, the block SHALL force IDLE asynchronously and clear all counters.
REQ-043 While rst=0, outputs SHALL be start_in=0, valid_input=0, X_load=0, read_n=1, r_addr=0, in_addr=0, res_valid=0, res_data=0, res_idx=0, busy=0, done=0, err_timeout=0.
REQ-044 Reset asserted mid-LOAD or mid-readback SHALL abort the job; no partial res_valid SHALL follow deassertion.

Verification
REQ-045 Scenario: job_go with an accelerator model that raises finish 50 cycles after the last valid_input -> one start_in per matrix; 32 consecutive valid_input cycles per matrix with X_load=mem[0..31] then mem[32..63]; exactly GAP_CYCLES idle cycles between finish and the 2nd start_in.
REQ-046 Scenario: readback with model read_data=r_addr in RD_LO and ~r_addr&9'h1FF in RD_HI -> 32 res_valid pulses, res_idx 0..31, each 5 cycles apart, res_data={~i[8:0],i[8:0]}; then done=1 for one cycle.
REQ-047 Scenario: finish never asserted -> err_timeout=1 exactly TIMEOUT cycles after entering WAIT_FIN; done pulses; no read_n=0 cycle occurs.
REQ-048 Scenario: finish pulsed during LOAD and GAP -> no state change; the FSM still waits in WAIT_FIN for a later finish.
REQ-049 Scenario: job_go re-pulsed during LOAD, and rst=0 asserted at word 17 of matrix 1 -> the re-pulse has no effect; after reset all outputs are at reset values; a new job_go restarts from in_addr=0.
